// File: rtl/alu_rr_sequencer_if.sv
// Requester, response and ALU-side signal bundle for alu_rr_sequencer.
// slave: sequencer side (i_* in, o_* out); master: environment side.
interface alu_rr_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             i_req0_valid;
  logic             o_req0_ready;
  logic [WIDTH-1:0] i_req0_arg0;
  logic [WIDTH-1:0] i_req0_arg1;
  logic [1:0]       i_req0_oper;
  logic             i_req1_valid;
  logic             o_req1_ready;
  logic [WIDTH-1:0] i_req1_arg0;
  logic [WIDTH-1:0] i_req1_arg1;
  logic [1:0]       i_req1_oper;
  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_result;
  logic [3:0]       o_rsp_flag;
  logic [WIDTH-1:0] o_alu_arg0;
  logic [WIDTH-1:0] o_alu_arg1;
  logic [1:0]       o_alu_oper;
  logic [WIDTH-1:0] i_alu_result;
  logic [3:0]       i_alu_flag;
  logic             o_busy;
  logic [CNT_W-1:0] o_err_cnt;

  modport slave (
    input  i_req0_valid, i_req0_arg0, i_req0_arg1, i_req0_oper,
    input  i_req1_valid, i_req1_arg0, i_req1_arg1, i_req1_oper,
    input  i_rsp_ready, i_alu_result, i_alu_flag,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_flag,
    output o_alu_arg0, o_alu_arg1, o_alu_oper,
    output o_busy, o_err_cnt
  );

  modport master (
    output i_req0_valid, i_req0_arg0, i_req0_arg1, i_req0_oper,
    output i_req1_valid, i_req1_arg0, i_req1_arg1, i_req1_oper,
    output i_rsp_ready, i_alu_result, i_alu_flag,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_flag,
    input  o_alu_arg0, o_alu_arg1, o_alu_oper,
    input  o_busy, o_err_cnt
  );
endinterface

// File: rtl/alu_rr_sequencer.sv
// Two-requester round-robin sequencer sharing one clocked ALU.
// Ports: i_clk, i_rst (async active-high), bus (alu_rr_sequencer_if.slave).
// Optional macro ALU_SEQ_ERRCNT_EN: saturating count of ERR-flag responses.
module alu_rr_sequencer #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  alu_rr_sequencer_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT    = 4'(ALU_LAT);

  logic [1:0]       r_state;
  logic             r_ptr;
  logic             r_id;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_arg0;
  logic [WIDTH-1:0] r_arg1;
  logic [1:0]       r_oper;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flag;

  logic w_g0;
  logic w_g1;
  logic w_idle;
  logic w_cap;

  // pointer requester wins; the other wins only if pointer one idle
  assign w_g0 = bus.i_req0_valid &
                (~r_ptr | ~bus.i_req1_valid);
  assign w_g1 = bus.i_req1_valid &
                (r_ptr | ~bus.i_req0_valid);
  // ready is held low during reset so every output reads 0
  assign w_idle = (r_state == S_IDLE) & ~i_rst;
  assign w_cap  = (r_state == S_EXEC) & (r_cnt == 4'd0);

  assign bus.o_req0_ready = w_idle & w_g0;
  assign bus.o_req1_ready = w_idle & w_g1;
  assign bus.o_rsp_valid  = (r_state == S_RESP);
  assign bus.o_rsp_id     = r_id;
  assign bus.o_rsp_result = r_rsp_result;
  assign bus.o_rsp_flag   = r_rsp_flag;
  assign bus.o_alu_arg0   = r_arg0;
  assign bus.o_alu_arg1   = r_arg1;
  assign bus.o_alu_oper   = r_oper;
  assign bus.o_busy       = (r_state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= 4'd0;
      r_arg0       <= '0;
      r_arg1       <= '0;
      r_oper       <= 2'd0;
      r_rsp_result <= '0;
      r_rsp_flag   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_g0 | w_g1) begin
            r_arg0  <= w_g1 ? bus.i_req1_arg0
                            : bus.i_req0_arg0;
            r_arg1  <= w_g1 ? bus.i_req1_arg1
                            : bus.i_req0_arg1;
            r_oper  <= w_g1 ? bus.i_req1_oper
                            : bus.i_req0_oper;
            r_id    <= w_g1;
            r_cnt   <= LAT;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // counter hits 0 one edge before capture so a
          // registered ALU output is sampled after ALU_LAT edges
          if (w_cap) begin
            r_rsp_result <= bus.i_alu_result;
            r_rsp_flag   <= bus.i_alu_flag;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.i_rsp_ready) begin
            r_state <= S_IDLE;
            r_ptr   <= ~r_id;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_ERRCNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_cap && bus.i_alu_flag[0] &&
                 (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign bus.o_err_cnt = r_err_cnt;
`else
  assign bus.o_err_cnt = '0;
`endif

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
Two-requester round-robin sequencer that shares one clocked ALU instance (TOP: i_arg0/i_arg1/i_oper in, o_result/o_flag out). Each requester hands over an operand pair and opcode through a valid/ready handshake. The block drives the ALU, waits the fixed ALU latency, captures result and flags, and returns them tagged with the requester ID. It sits between the two requester channels and the ALU inside the datapath top level.

Parameters:
WIDTH, 4, operand/result width; must match the ALU WIDTH
ALU_LAT, 1, ALU clock cycles from operands stable to o_result/o_flag valid; legal range 1..15
CNT_W, 8, width of error counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req0_valid  in  1  requester 0 has an operation
o_req0_ready  out  1  requester 0 operation accepted this cycle
i_req0_arg0  in  WIDTH  requester 0 operand A
i_req0_arg1  in  WIDTH  requester 0 operand B
i_req0_oper  in  2  requester 0 opcode (00 sub, 01 NAND, 10 leading ones, 11 one-hot decode)
i_req1_valid, o_req1_ready, i_req1_arg0, i_req1_arg1, i_req1_oper  same as requester 0, for requester 1
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  response consumer ready
o_rsp_id  out  1  requester that issued the response
o_rsp_result  out  WIDTH  captured ALU result
o_rsp_flag  out  4  captured ALU flags ([0] ERR, [1] NEG, [2] POS, [3] OVERFLOW)
o_alu_arg0  out  WIDTH  to ALU i_arg0
o_alu_arg1  out  WIDTH  to ALU i_arg1
o_alu_oper  out  2  to ALU i_oper
i_alu_result  in  WIDTH  from ALU o_result
i_alu_flag  in  4  from ALU o_flag
o_busy  out  1  high whenever state is not IDLE
o_err_cnt  out  CNT_W  ERR-flag response count (see Optional Feature)

Behaviour:
- Reset (i_rst high, asynchronous): state IDLE; RR pointer selects requester 0; all operand, response and counter registers 0; all outputs 0.
- States: IDLE, EXEC, RESP.
- IDLE: grant goes to the pointer requester if it is valid, else to the other requester if valid. o_reqN_ready = (state==IDLE) && grantN. This path is combinational and never depends on ready.
- Accept at a valid&ready edge: register the operands, opcode and ID; load latency counter with ALU_LAT; go to EXEC.
- o_alu_* are driven only from the operand registers and are held stable from the accept edge until the next accept.
- EXEC: decrement the counter each edge. On the edge where it reaches 0, capture i_alu_result/i_alu_flag into o_rsp_result/o_rsp_flag, then go to RESP.
  - o_rsp_valid rises ALU_LAT+1 cycles after the accept edge.
- RESP: o_rsp_valid=1. Result, flag and ID are held stable until i_rsp_ready.
  - On the handshake edge: go to IDLE; pointer = inverse of the served ID; o_rsp_valid falls.
- With i_rsp_ready held high, the RESP state lasts 1 cycle. Back-to-back accepts are therefore ALU_LAT+3 cycles apart.
- Both valid in IDLE: the pointer requester wins. With both held continuously, grants alternate 0,1,0,1.
- Requests presented in EXEC or RESP: ready stays 0. The requester must hold valid and its data; no request is ever dropped.
- Requester deasserting valid before ready: legal. Nothing is captured.
- Reset mid-operation: the in-flight operation and its response are discarded with no partial response; the block restarts from the reset state.

Optional Feature:
Macro ALU_SEQ_ERRCNT_EN.
- Defined: o_err_cnt increments on every capture edge where i_alu_flag[0]==1. It saturates at 2^CNT_W-1 and clears only on reset.
- Undefined: o_err_cnt is tied to 0 and no counter register exists. All other behaviour is identical.

Test Plan:
- Reset, then req0 NAND arg0=1111 arg1=0001, rsp_ready=1, ALU_LAT=1 -> o_req0_ready high 1 cycle; o_alu_oper=01 from accept; o_rsp_valid exactly 2 cycles after accept; result=1110, id=0.
- req0 and req1 valid together, continuously, 4 operations -> response ids 0,1,0,1; each response matches the ALU reference model for its own operands.
- rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid/result/flag/id stable throughout; req1 held valid sees ready=0 until the handshake.
- i_rst pulsed 1 cycle during EXEC -> all outputs 0 immediately (before next clock edge); no response ever appears for that op; the next request is served normally with pointer at 0.
- ALU_LAT=3 build, one op -> o_rsp_valid 4 cycles after accept; o_alu_* unchanged across EXEC.
- ALU_SEQ_ERRCNT_EN with CNT_W=2 and ALU model forcing ERR on 5 ops -> o_err_cnt 1,2,3,3,3. Without the macro -> o_err_cnt always 0.
